// File: rtl/carregador_instrucoes.sv
// -----------------------------------------------------------------------------
// carregador_instrucoes
//
// Boot loader that streams a program from a host byte channel into the
// instruction memory while keeping the processor in reset. The first byte of
// a load is the program length L (0 encodes 256). The next L bytes are written
// to consecutive memory addresses starting at END_BASE, wrapping modulo 256.
// After the last byte the processor reset is held for RELEASE_CYCLES more
// cycles and then released.
//
// Optional feature (macro CARREGADOR_CHECKSUM_EN): one extra byte follows the
// program and must equal the mod-256 sum of the program bytes. On a mismatch
// the load aborts into an error state and the processor stays in reset.
//
// Parameters
//   RELEASE_CYCLES  cycles cpu_reset stays high after the last byte (1..15)
//   END_BASE        memory address receiving the first program byte
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse requesting a (re)load, honoured in IDLE/RUN/ERROR
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   loader accepts a byte this cycle (LEN, LOAD, CHK)
//   mem_we     instruction memory write strobe (one cycle per program byte)
//   mem_addr   instruction memory write address
//   mem_wdata  instruction memory write data
//   cpu_reset  processor reset, low only in RUN
//   done       program loaded and processor running
//   err        load aborted on checksum mismatch
//   count      program bytes written in the current load
// -----------------------------------------------------------------------------
module carregador_instrucoes #(
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter logic [7:0]  END_BASE       = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_reset,
    output logic       done,
    output logic       err,
    output logic [8:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CHK,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    // RELEASE counts down from RELEASE_CYCLES-1 to 0, giving exactly
    // RELEASE_CYCLES cycles in that state.
    localparam logic [3:0] REL_INIT = 4'(RELEASE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [8:0] len_q,   len_d;     // program length, 1..256
    logic [8:0] count_q, count_d;
    logic [3:0] rel_q,   rel_d;
    logic       we_q,    we_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] wdata_q, wdata_d;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0] sum_q,   sum_d;
`endif

    logic accept;

    assign in_ready = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign accept   = in_valid && in_ready;

    // NOTE: every signal driven here gets its default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        rel_d   = rel_q;
        we_d    = 1'b0;         // write strobe is a single-cycle pulse
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef CARREGADOR_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    count_d = 9'd0;
`ifdef CARREGADOR_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end

            S_LEN: begin
                if (accept) begin
                    len_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = END_BASE + count_q[7:0];  // wraps naturally at 8 bits
                    wdata_d = in_data;
                    count_d = count_q + 9'd1;
`ifdef CARREGADOR_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                    if (count_q + 9'd1 == len_q) begin
`ifdef CARREGADOR_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RELEASE;
                        rel_d   = REL_INIT;
`endif
                    end
                end
            end

`ifdef CARREGADOR_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = S_RELEASE;
                        rel_d   = REL_INIT;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
`endif

            S_RELEASE: begin
                if (rel_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    rel_d = rel_q - 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 9'd0;
            count_q <= 9'd0;
            rel_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
`ifdef CARREGADOR_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            rel_q   <= rel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef CARREGADOR_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign cpu_reset = (state_q != S_RUN);
    assign done      = (state_q == S_RUN);
`ifdef CARREGADOR_CHECKSUM_EN
    assign err       = (state_q == S_ERROR);
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_carregador_instrucoes.sv
// -----------------------------------------------------------------------------
// tb_carregador_instrucoes
//
// Two loaders share one host stream: u_dut0 with the default base 00 and a
// 2-cycle release, u_dut1 with base FE and a 3-cycle release. For every load
// the stimulus pushes the expected memory writes (base + k mod 256, byte k)
// and the expected end event (processor released with count = L, or error)
// into per-DUT queues; a negedge monitor pops and compares whenever a DUT
// writes memory, releases the processor or raises err.
// -----------------------------------------------------------------------------
module tb_carregador_instrucoes;

    localparam int         RC0   = 2;
    localparam int         RC1   = 3;
    localparam logic [7:0] BASE0 = 8'h00;
    localparam logic [7:0] BASE1 = 8'hFE;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic [1:0]      rdy_w, we_w, cr_w, done_w, err_w;
    logic [1:0][7:0] addr_w, wdata_w;
    logic [1:0][8:0] cnt_w;

    always #5 clk = ~clk;

    carregador_instrucoes #(.RELEASE_CYCLES(RC0), .END_BASE(BASE0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[0]), .mem_we(we_w[0]), .mem_addr(addr_w[0]), .mem_wdata(wdata_w[0]),
        .cpu_reset(cr_w[0]), .done(done_w[0]), .err(err_w[0]), .count(cnt_w[0])
    );

    carregador_instrucoes #(.RELEASE_CYCLES(RC1), .END_BASE(BASE1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[1]), .mem_we(we_w[1]), .mem_addr(addr_w[1]), .mem_wdata(wdata_w[1]),
        .cpu_reset(cr_w[1]), .done(done_w[1]), .err(err_w[1]), .count(cnt_w[1])
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wr_q0[$];
    wr_t wr_q1[$];
    int  done_q0[$];
    int  done_q1[$];
    int  err_q0[$];
    int  err_q1[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] payload [256];
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    task automatic push_write(input int k, input logic [7:0] b);
        wr_t e;
        e.data = b;
        e.addr = BASE0 + 8'(k);
        wr_q0.push_back(e);
        e.addr = BASE1 + 8'(k);
        wr_q1.push_back(e);
    endtask

    // -------------------------------------------------------------- monitor
    int cyc = 0;
    int last_acc [2];
    logic [1:0] prev_cr  = 2'b11;
    logic [1:0] prev_err = 2'b00;

    always @(negedge clk) begin : monitor
        wr_t e;
        int  n;
        bit  have;
        cyc = cyc + 1;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (in_valid && rdy_w[d]) last_acc[d] = cyc;

                if (we_w[d]) begin
                    have = 1'b0;
                    if (d == 0 && wr_q0.size() > 0) begin e = wr_q0.pop_front(); have = 1'b1; end
                    if (d == 1 && wr_q1.size() > 0) begin e = wr_q1.pop_front(); have = 1'b1; end
                    if (!have) check($sformatf("unexpected_write_dut%0d", d), we_w[d], 1'b0);
                    else begin
                        check($sformatf("wr_addr_dut%0d", d), addr_w[d], e.addr);
                        check($sformatf("wr_data_dut%0d", d), wdata_w[d], e.data);
                    end
                end

                if (prev_cr[d] && !cr_w[d]) begin
                    have = 1'b0;
                    if (d == 0 && done_q0.size() > 0) begin n = done_q0.pop_front(); have = 1'b1; end
                    if (d == 1 && done_q1.size() > 0) begin n = done_q1.pop_front(); have = 1'b1; end
                    if (!have) check($sformatf("unexpected_release_dut%0d", d), cr_w[d], 1'b1);
                    else begin
                        check($sformatf("run_count_dut%0d", d), cnt_w[d], n);
                        check($sformatf("run_done_dut%0d", d), done_w[d], 1'b1);
                        check($sformatf("run_err_dut%0d", d), err_w[d], 1'b0);
                        // accept edge follows the last-accept negedge by one cycle
                        check($sformatf("release_delay_dut%0d", d), cyc - last_acc[d],
                              (d == 0 ? RC0 : RC1) + 1);
                    end
                end

                if (!prev_err[d] && err_w[d]) begin
                    have = 1'b0;
                    if (d == 0 && err_q0.size() > 0) begin n = err_q0.pop_front(); have = 1'b1; end
                    if (d == 1 && err_q1.size() > 0) begin n = err_q1.pop_front(); have = 1'b1; end
                    if (!have) check($sformatf("unexpected_err_dut%0d", d), err_w[d], 1'b0);
                    else begin
                        check($sformatf("err_cpu_reset_dut%0d", d), cr_w[d], 1'b1);
                        check($sformatf("err_done_dut%0d", d), done_w[d], 1'b0);
                        check($sformatf("err_count_dut%0d", d), cnt_w[d], n);
                    end
                end
            end
        end
        prev_cr  = cr_w;
        prev_err = err_w;
    end

    // ------------------------------------------------------------- stimulus
    // All drivers are called at posedge+1 and return at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_in_ready_dut%0d", tag, d), rdy_w[d], 1'b0);
            check($sformatf("%s_mem_we_dut%0d", tag, d), we_w[d], 1'b0);
            check($sformatf("%s_mem_addr_dut%0d", tag, d), addr_w[d], 8'h00);
            check($sformatf("%s_mem_wdata_dut%0d", tag, d), wdata_w[d], 8'h00);
            check($sformatf("%s_cpu_reset_dut%0d", tag, d), cr_w[d], 1'b1);
            check($sformatf("%s_done_dut%0d", tag, d), done_w[d], 1'b0);
            check($sformatf("%s_err_dut%0d", tag, d), err_w[d], 1'b0);
            check($sformatf("%s_count_dut%0d", tag, d), cnt_w[d], 9'h000);
        end
    endtask

    // After start the loader sits in LEN: ready, processor in reset, flags clear.
    task automatic check_after_start();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("len_in_ready_dut%0d", d), rdy_w[d], 1'b1);
            check($sformatf("len_cpu_reset_dut%0d", d), cr_w[d], 1'b1);
            check($sformatf("len_done_dut%0d", d), done_w[d], 1'b0);
            check($sformatf("len_err_dut%0d", d), err_w[d], 1'b0);
            check($sformatf("len_count_dut%0d", d), cnt_w[d], 9'h000);
        end
        @(posedge clk); #1;
    endtask

    // gap < 0 picks a random stall of 0..3 cycles before the byte.
    task automatic send_byte(input logic [7:0] b, input int gap, input int exp_cnt);
        int g;
        int n;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        n = 0;
        while (rdy_w != 2'b11 && n < 20) begin @(negedge clk); n++; end
        check("byte_in_ready", rdy_w, 2'b11);
        check("count_dut0", cnt_w[0], exp_cnt);
        check("count_dut1", cnt_w[1], exp_cnt);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input bit want_err);
        int n;
        n = 0;
        @(negedge clk);
        while (n < 64 && !(want_err ? (err_w == 2'b11) : (done_w == 2'b11))) begin
            @(negedge clk);
            n++;
        end
        check("load_end_timeout", 32'(n < 64), 1);
        @(posedge clk); #1;
    endtask

    // One complete load of payload[0..len-1]. start_at injects a start pulse
    // alongside that LOAD byte; start_in_rel pulses start during RELEASE.
    task automatic run_load(input int len, input int gap, input int start_at,
                            input bit start_in_rel, input bit bad_chk);
        logic [7:0] sum;
        sum = 8'h00;
        pulse_start();
        check_after_start();
`ifdef CARREGADOR_CHECKSUM_EN
        if (bad_chk) begin err_q0.push_back(len); err_q1.push_back(len); end
        else begin done_q0.push_back(len); done_q1.push_back(len); end
`else
        done_q0.push_back(len);
        done_q1.push_back(len);
`endif
        send_byte(8'(len), gap, 0);
        for (int k = 0; k < len; k++) begin
            push_write(k, payload[k]);
            sum = sum + payload[k];
            if (k == start_at) start = 1'b1;
            send_byte(payload[k], gap, k);
            start = 1'b0;
        end
`ifdef CARREGADOR_CHECKSUM_EN
        send_byte(bad_chk ? sum + 8'd1 : sum, gap, len);
`endif
        if (start_in_rel) pulse_start();
        wait_end(bad_chk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int len;

        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");
        @(posedge clk); #1;

        // 03,11,22,33 streamed back to back; dut1 wraps FE,FF,00
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        run_load(3, 0, -1, 1'b0, 1'b0);

        // same load with in_valid 1,0,0,1 pattern; reload from RUN
        run_load(3, 2, -1, 1'b0, 1'b0);

        // start ignored in LOAD and in RELEASE
        for (int i = 0; i < 6; i++) payload[i] = 8'($urandom);
        run_load(6, 0, 2, 1'b1, 1'b0);

        // reset on the cycle after the 2nd LOAD byte
        pulse_start();
        check_after_start();
        send_byte(8'd5, 0, 0);
        push_write(0, 8'hA5);
        send_byte(8'hA5, 0, 0);
        push_write(1, 8'h5A);
        send_byte(8'h5A, 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;

        // L = 0 means 256 bytes; count reaches 100h
        for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
        run_load(256, 0, -1, 1'b0, 1'b0);

        // random programs with random stalls
        for (int t = 0; t < 6; t++) begin
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
            run_load(len, -1, -1, 1'b0, 1'b0);
        end

`ifdef CARREGADOR_CHECKSUM_EN
        // 02,10,20 then checksum 30 (good) and 31 (bad), then recover
        payload[0] = 8'h10; payload[1] = 8'h20;
        run_load(2, 0, -1, 1'b0, 1'b0);
        run_load(2, 0, -1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("err_held_cpu_reset", cr_w, 2'b11);
        check("err_held_err", err_w, 2'b11);
        run_load(2, -1, -1, 1'b0, 1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("writes_left_dut0", wr_q0.size(), 0);
        check("writes_left_dut1", wr_q1.size(), 0);
        check("runs_left_dut0", done_q0.size(), 0);
        check("runs_left_dut1", done_q1.size(), 0);
        check("errs_left_dut0", err_q0.size(), 0);
        check("errs_left_dut1", err_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/carregador_instrucoes.md
CARREGADOR_INSTRUCOES -- requirements
Module: carregador_instrucoes

Interface
REQ-001 SHALL have parameter RELEASE_CYCLES, default 2: cycles cpu_reset stays high after the last write, range 1..15.
REQ-002 SHALL have parameter END_BASE, default 8'h00: instruction memory address receiving the first program byte.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse requesting a (re)load.
REQ-006 SHALL have port in_valid, input, 1: host byte valid.
REQ-007 SHALL have port in_data, input, 8: host byte.
REQ-008 SHALL have port in_ready, output, 1: block accepts a byte this cycle.
REQ-009 SHALL have ports mem_we (output, 1), mem_addr (output, 8) and mem_wdata (output, 8): instruction memory write port.
REQ-010 SHALL have port cpu_reset, output, 1: drives the processor reset, high while loading.
REQ-011 SHALL have ports done (output, 1: program loaded, processor running) and err (output, 1: load aborted).
REQ-012 SHALL have port count, output, 9: bytes written in the current load.

Function
REQ-013 SHALL implement states IDLE, LEN, LOAD, CHK, RELEASE, RUN and ERROR.
REQ-014 SHALL transfer a byte only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL drive in_ready = 1 exactly in LEN, LOAD and CHK.
REQ-016 SHALL move IDLE->LEN on start; the first byte accepted in LEN is length L, with L=0 meaning 256, and the state moves to LOAD.
REQ-017 SHALL, for the k-th byte accepted in LOAD (k=0..), assert mem_we=1 with mem_addr=END_BASE+k mod 256 and mem_wdata=byte on the following cycle only; mem_we is 0 on all other cycles.
REQ-018 SHALL increment count per LOAD byte; after the L-th byte it moves to CHK when CHECKSUM_EN is defined, otherwise to RELEASE.
REQ-019 SHALL hold every output and the state when in_valid=0 (stalls of any length).
REQ-020 SHALL hold cpu_reset=1 in all states except RUN.
REQ-021 SHALL stay in RELEASE for exactly RELEASE_CYCLES cycles and then enter RUN, where cpu_reset=0 and done=1.
REQ-022 SHALL, on start in RUN or ERROR, go to LEN on the next edge with cpu_reset=1, done=0, err=0 and count=0.
REQ-023 SHALL ignore start in LEN, LOAD, CHK and RELEASE.
REQ-024 SHALL wrap mem_addr from 8'hFF to 8'h00 without error.
REQ-025 SHALL, when L=256, accept exactly 256 bytes and reach count=9'h100.

Reset
REQ-026 SHALL, when reset=1 at an edge, enter IDLE with cpu_reset=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0 and count=0.
REQ-027 SHALL give reset priority over start and over any transfer on the same edge.
REQ-028 SHALL, when reset occurs mid-load, complete no pending write; bytes already written are left in memory.

Configuration
REQ-029 SHALL, with macro CARREGADOR_CHECKSUM_EN defined, keep an 8-bit mod-256 sum of the LOAD bytes; the single CHK byte must equal that sum.
REQ-030 SHALL, on a match, go CHK->RELEASE; on a mismatch it goes to ERROR with err=1, cpu_reset=1 and done=0.
REQ-031 SHALL, without CARREGADOR_CHECKSUM_EN, omit CHK and the sum logic; err then stays 0.

Verification
REQ-032 SHALL cover: start, bytes 03,11,22,33 with in_valid always 1 -> writes at addresses 00,01,02 of data 11,22,33, count=3; cpu_reset falls 2 cycles after the last write; done=1.
REQ-033 SHALL cover: the same load with in_valid toggling 1,0,0,1 -> identical write sequence and no extra mem_we.
REQ-034 SHALL cover: END_BASE=FE with L=3 -> addresses FE, FF, 00.
REQ-035 SHALL cover: L=00 followed by 256 bytes -> 256 writes, count=100h, then RUN.
REQ-036 SHALL cover, with CARREGADOR_CHECKSUM_EN: 02,10,20,checksum 30 -> RUN; checksum 31 -> err=1 and cpu_reset held; then start -> LEN with err=0.
REQ-037 SHALL cover: reset asserted on the cycle after the 2nd LOAD byte -> next cycle IDLE, mem_we=0, count=0, cpu_reset=1.
